mant_sub_normalizer: RTL and testbench
======================================

Name: mant_sub_normalizer

Overview:
- Multi-cycle mantissa subtractor and normalizer for the effective-subtraction path of the FP MAC.
- Computes |a_man - b_man| with a borrow prefix network evaluated one level per clock. The borrow combine is GG = G1 | (P1 & G0), with g_i = ~a_i & b_i and p_i = ~(a_i ^ b_i).
- After the prefix network it left-normalizes the result, decrementing the exponent once per shift.
- Sits between the alignment shifter and the rounder; uses a valid/ready handshake on both sides.

Parameters:
- WIDTH, 24, mantissa width in bits including the hidden bit.
- EXP_W, 8, exponent width in bits.
- LEVELS, clog2(WIDTH) (5 at the default), number of prefix levels; derived, not overridable.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- a_man  input  WIDTH  minuend mantissa, aligned.
- b_man  input  WIDTH  subtrahend mantissa, aligned.
- exp_in  input  EXP_W  common exponent after alignment.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- diff_man  output  WIDTH  normalized |a-b|.
- exp_out  output  EXP_W  adjusted exponent.
- sign  output  1  1 when a_man < b_man.
- zero  output  1  1 when the result is exactly zero.
- underflow  output  1  normalization stopped because the exponent reached 0.

Behaviour:
- Reset (asynchronous, active-high, any state):
  - State returns to IDLE; in_ready=1.
  - out_valid, sign, zero, underflow = 0; diff_man = 0; exp_out = 0.
  - The internal g/p/operand registers are cleared.
  - An in-flight operation is discarded; there is no partial output.
- States: IDLE, PREFIX, RESOLVE, NORM, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid=1 at a clock edge: register a_man, b_man, exp_in and initial g/p vectors; clear the level counter; go to PREFIX.
- PREFIX:
  - in_ready=0.
  - Each cycle applies one Kogge-Stone level of span 2^lvl to all bit positions. Positions below the span keep their value.
  - After LEVELS cycles, go to RESOLVE.
- RESOLVE (1 cycle):
  - Raw difference = a ^ b ^ {borrow[WIDTH-2:0], 0}; borrow_out = borrow[WIDTH-1].
  - If borrow_out=1: sign=1 and the mantissa is two's-complement negated; otherwise sign=0. Negation happens in this cycle.
  - Result zero: zero=1, diff_man=0, exp_out=0, go to DONE.
  - MSB already set: go to DONE with exp_out = exp_in.
  - Otherwise: go to NORM.
- NORM:
  - While MSB=0 and exp>0: shift left 1 (LSB fill 0) and decrement exp, one shift per cycle.
  - MSB=1: go to DONE, underflow=0.
  - exp==0 with MSB=0: go to DONE, underflow=1, mantissa left as-is (denormal).
  - Exp is never decremented below 0.
- DONE:
  - out_valid=1; all outputs held stable until out_ready=1.
  - On the handshake edge: out_valid falls and state returns to IDLE.
  - in_ready=0 in DONE, so a new operand is accepted no earlier than the cycle after the output handshake.
  - Result outputs keep their last value in IDLE; only out_valid indicates validity.
- Latency (accept edge to out_valid high): LEVELS+1 clocks plus 1 per normalization shift.
  - Minimum 6, maximum 6+(WIDTH-1) at defaults.
- Throughput: one operation in flight; no overlap.
- exp_in=0 with an unnormalized result: no shifts, underflow=1 straight from RESOLVE via NORM (one NORM cycle).
- Widths: all arithmetic is modulo WIDTH. Borrow-out is used only for sign; it is never carried into exp.

Test Plan:
- Reset values: assert rst mid-PREFIX with operands loaded -> immediately in_ready=1, out_valid=0, all outputs 0. Next accepted operation behaves normally.
- One-shift normalize: a=0x800000, b=0x400000, exp_in=10 -> diff_man=0x800000, exp_out=9, sign=0, zero=0, underflow=0, out_valid 7 clocks after accept.
- Negative result: a=0x400000, b=0xC00000, exp_in=20 -> sign=1, diff_man=0x800000, exp_out=20, latency 6.
- Exact zero: a=b=0x9ABCDE, exp_in=50 -> zero=1, diff_man=0, exp_out=0, sign=0, latency 6.
- Underflow: a=0x000003, b=0x000001, exp_in=2 -> diff_man=0x000008, exp_out=0, underflow=1, latency 8.
- Back-pressure: hold out_ready=0 for 4 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored. out_ready=1 -> out_valid falls next edge, in_ready=1.

Source files
------------

// File: rtl/mant_sub_normalizer.sv
// mant_sub_normalizer
//   Multi-cycle |a - b| mantissa subtractor with left normalization, for the
//   effective-subtraction path of the FP MAC. The borrow chain is resolved by
//   a Kogge-Stone prefix network, one level per clock. The result is then
//   shifted left one bit per clock, with the exponent decremented per shift,
//   until the MSB is set or the exponent reaches zero.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   operand handshake (accepted only in IDLE)
//   a_man, b_man, exp_in  aligned mantissas and their common exponent
//   out_valid / out_ready result handshake (result held until accepted)
//   diff_man, exp_out     normalized magnitude and adjusted exponent
//   sign                  a_man < b_man
//   zero                  exact zero result
//   underflow             normalization stopped at exponent 0 (denormal)
module mant_sub_normalizer #(
  parameter int WIDTH = 24,
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_man,
  input  logic [WIDTH-1:0] b_man,
  input  logic [EXP_W-1:0] exp_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff_man,
  output logic [EXP_W-1:0] exp_out,
  output logic             sign,
  output logic             zero,
  output logic             underflow
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int LVL_W  = $clog2(LEVELS + 1);

  typedef enum logic [2:0] {S_IDLE, S_PREFIX, S_RESOLVE, S_NORM, S_DONE} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] g_q, g_d, p_q, p_d;
  logic [EXP_W-1:0] ein_q, ein_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic [WIDTH-1:0] man_q, man_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic             sign_q, sign_d, zero_q, zero_d, uf_q, uf_d;

  // After the last level g_q[i] is the borrow out of bit i, i.e. the borrow
  // into bit i+1; bit 0 never receives a borrow.
  logic [WIDTH-1:0] raw, mag, nshift;
  logic [EXP_W-1:0] nexp;
  logic             bout, last_lvl;

  always_comb begin
    raw      = a_q ^ b_q ^ {g_q[WIDTH-2:0], 1'b0};
    bout     = g_q[WIDTH-1];
    mag      = bout ? (~raw + WIDTH'(1)) : raw;
    nshift   = man_q << 1;
    nexp     = exp_q - EXP_W'(1);
    last_lvl = (lvl_q == LVL_W'(LEVELS - 1));
  end

  // ---- FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---- FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (in_valid) state_d = S_PREFIX;
      S_PREFIX:  if (last_lvl) state_d = S_RESOLVE;
      S_RESOLVE: state_d = (mag == '0 || mag[WIDTH-1]) ? S_DONE : S_NORM;
      // Exit on the same edge the shift lands the MSB or exhausts the exponent.
      S_NORM:    if (exp_q == '0 || nshift[WIDTH-1] || nexp == '0) state_d = S_DONE;
      S_DONE:    if (out_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // ---- FSM: outputs
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // ---- datapath next state
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    g_d    = g_q;
    p_d    = p_q;
    ein_d  = ein_q;
    lvl_d  = lvl_q;
    man_d  = man_q;
    exp_d  = exp_q;
    sign_d = sign_q;
    zero_d = zero_q;
    uf_d   = uf_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d   = a_man;
          b_d   = b_man;
          ein_d = exp_in;
          g_d   = ~a_man & b_man;
          p_d   = ~(a_man ^ b_man);
          lvl_d = '0;
        end
      end
      S_PREFIX: begin
        // Span 2^lvl; positions below the span see zero generate / unit
        // propagate from the shifted copy, so they keep their value.
        for (int k = 0; k < LEVELS; k++) begin
          if (lvl_q == LVL_W'(k)) begin
            g_d = g_q | (p_q & (g_q << (1 << k)));
            p_d = p_q & ((p_q << (1 << k)) | ((WIDTH'(1) << (1 << k)) - WIDTH'(1)));
          end
        end
        lvl_d = lvl_q + LVL_W'(1);
      end
      S_RESOLVE: begin
        sign_d = bout;
        zero_d = (mag == '0);
        uf_d   = 1'b0;
        man_d  = mag;
        exp_d  = (mag == '0) ? '0 : ein_q;
      end
      S_NORM: begin
        if (exp_q == '0) begin
          uf_d = 1'b1;
        end else begin
          man_d = nshift;
          exp_d = nexp;
          uf_d  = ~nshift[WIDTH-1] && (nexp == '0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      g_q    <= '0;
      p_q    <= '0;
      ein_q  <= '0;
      lvl_q  <= '0;
      man_q  <= '0;
      exp_q  <= '0;
      sign_q <= 1'b0;
      zero_q <= 1'b0;
      uf_q   <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      g_q    <= g_d;
      p_q    <= p_d;
      ein_q  <= ein_d;
      lvl_q  <= lvl_d;
      man_q  <= man_d;
      exp_q  <= exp_d;
      sign_q <= sign_d;
      zero_q <= zero_d;
      uf_q   <= uf_d;
    end
  end

  assign diff_man  = man_q;
  assign exp_out   = exp_q;
  assign sign      = sign_q;
  assign zero      = zero_q;
  assign underflow = uf_q;

endmodule

// File: tb/tb_mant_sub_normalizer.sv
module tb_mant_sub_normalizer;
  localparam int WIDTH = 24;
  localparam int EXP_W = 8;
  localparam int TMO   = 200;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] a_man, b_man, diff_man;
  logic [EXP_W-1:0] exp_in, exp_out;
  logic             sign, zero, underflow;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mant_sub_normalizer #(.WIDTH(WIDTH), .EXP_W(EXP_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_man(a_man), .b_man(b_man), .exp_in(exp_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff_man(diff_man), .exp_out(exp_out),
    .sign(sign), .zero(zero), .underflow(underflow)
  );

  typedef struct packed {
    logic [WIDTH-1:0] man;
    logic [EXP_W-1:0] e;
    logic             sign;
    logic             zero;
    logic             uf;
    logic [31:0]      lat;
  } res_t;

  // Reference: plain integer |a-b|, count leading zeros, shift by as much as
  // the exponent allows.
  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [EXP_W-1:0] e);
    res_t r;
    longint d;
    int lz, k, ei;
    ei     = int'(e);
    r      = '0;
    r.sign = (a < b);
    d      = r.sign ? (longint'(b) - longint'(a)) : (longint'(a) - longint'(b));
    if (d == 0) begin
      r.zero = 1'b1;
      r.lat  = 6;
      return r;
    end
    lz = 0;
    while (((d >> (WIDTH - 1 - lz)) & 1) == 0) lz++;
    if (lz == 0) begin
      r.man = WIDTH'(d); r.e = e; r.lat = 6;
    end else if (ei == 0) begin
      r.man = WIDTH'(d); r.e = '0; r.uf = 1'b1; r.lat = 7;
    end else begin
      k     = (lz < ei) ? lz : ei;
      r.man = WIDTH'(d << k);
      r.e   = EXP_W'(ei - k);
      r.uf  = (lz > ei);
      r.lat = 32'(6 + k);
    end
    return r;
  endfunction

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [EXP_W-1:0] e);
    @(negedge clk);
    a_man = a; b_man = b; exp_in = e; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < TMO) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_man = '0; b_man = '0; exp_in = '0;
    #12;
    n_cmp++;
    if ({in_ready, out_valid, diff_man, exp_out, sign, zero, underflow} !== {2'b10, {(WIDTH+EXP_W+3){1'b0}}}) begin
      n_err++;
      $display("FAIL reset_state: rdy=%b vld=%b man=%h exp=%0d s=%b z=%b uf=%b, want rdy=1 rest 0",
               in_ready, out_valid, diff_man, exp_out, sign, zero, underflow);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic [WIDTH-1:0] a, b;
    logic [EXP_W-1:0] e;
    logic [WIDTH-1:0] man;
    logic [EXP_W-1:0] eo;
    logic             s, z, uf;
    logic [7:0]       lat;
  } dvec_t;

  task automatic test_directed();
    dvec_t tbl[4];
    int lat;
    tbl[0] = '{24'h800000, 24'h400000, 8'd10, 24'h800000, 8'd9,  1'b0, 1'b0, 1'b0, 8'd7};
    tbl[1] = '{24'h400000, 24'hC00000, 8'd20, 24'h800000, 8'd20, 1'b1, 1'b0, 1'b0, 8'd6};
    tbl[2] = '{24'h9ABCDE, 24'h9ABCDE, 8'd50, 24'h000000, 8'd0,  1'b0, 1'b1, 1'b0, 8'd6};
    tbl[3] = '{24'h000003, 24'h000001, 8'd2,  24'h000008, 8'd0,  1'b0, 1'b0, 1'b1, 8'd8};
    foreach (tbl[i]) begin
      issue(tbl[i].a, tbl[i].b, tbl[i].e);
      wait_result(lat);
      n_cmp++;
      if (lat !== int'(tbl[i].lat)) begin
        n_err++;
        $display("FAIL directed%0d_latency: got %0d want %0d", i, lat, tbl[i].lat);
      end
      n_cmp++;
      if ({diff_man, exp_out, sign, zero, underflow} !==
          {tbl[i].man, tbl[i].eo, tbl[i].s, tbl[i].z, tbl[i].uf}) begin
        n_err++;
        $display("FAIL directed%0d_result: got man=%h exp=%0d s=%b z=%b uf=%b want man=%h exp=%0d s=%b z=%b uf=%b",
                 i, diff_man, exp_out, sign, zero, underflow,
                 tbl[i].man, tbl[i].eo, tbl[i].s, tbl[i].z, tbl[i].uf);
      end
      release_out();
      n_cmp++;
      if ({out_valid, in_ready} !== 2'b01) begin
        n_err++;
        $display("FAIL directed%0d_handshake: got vld=%b rdy=%b want vld=0 rdy=1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_reset_midflight();
    res_t r;
    int lat;
    // Outputs still hold the previous (non-zero) result here.
    issue(24'hFFFFFF, 24'h000123, 8'd77);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, diff_man, exp_out, sign, zero, underflow} !== {2'b10, {(WIDTH+EXP_W+3){1'b0}}}) begin
      n_err++;
      $display("FAIL reset_midflight: rdy=%b vld=%b man=%h exp=%0d s=%b z=%b uf=%b, want rdy=1 rest 0",
               in_ready, out_valid, diff_man, exp_out, sign, zero, underflow);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_no_partial: out_valid=%b want 0", out_valid);
    end
    r = model(24'h001000, 24'h003000, 8'd15);
    issue(24'h001000, 24'h003000, 8'd15);
    wait_result(lat);
    n_cmp++;
    if ({diff_man, exp_out, sign, zero, underflow, 32'(lat)} !== {r.man, r.e, r.sign, r.zero, r.uf, r.lat}) begin
      n_err++;
      $display("FAIL post_reset_op: got man=%h exp=%0d s=%b z=%b uf=%b lat=%0d want man=%h exp=%0d s=%b z=%b uf=%b lat=%0d",
               diff_man, exp_out, sign, zero, underflow, lat, r.man, r.e, r.sign, r.zero, r.uf, r.lat);
    end
    release_out();
  endtask

  task automatic test_random();
    res_t r;
    int lat, mode;
    logic [WIDTH-1:0] a, b;
    logic [EXP_W-1:0] e;
    for (int i = 0; i < 60; i++) begin
      mode = $urandom_range(0, 2);
      a = WIDTH'($urandom);
      case (mode)
        0:       b = WIDTH'($urandom);
        1:       b = a ^ (WIDTH'($urandom) >> $urandom_range(0, WIDTH - 1));
        default: b = a + WIDTH'($urandom_range(0, 3));
      endcase
      e = (mode == 0) ? EXP_W'($urandom_range(0, 255)) : EXP_W'($urandom_range(0, 12));
      r = model(a, b, e);
      issue(a, b, e);
      wait_result(lat);
      n_cmp++;
      if ({diff_man, exp_out, sign, zero, underflow, 32'(lat)} !== {r.man, r.e, r.sign, r.zero, r.uf, r.lat}) begin
        n_err++;
        $display("FAIL random%0d a=%h b=%h e=%0d: got man=%h exp=%0d s=%b z=%b uf=%b lat=%0d want man=%h exp=%0d s=%b z=%b uf=%b lat=%0d",
                 i, a, b, e, diff_man, exp_out, sign, zero, underflow, lat,
                 r.man, r.e, r.sign, r.zero, r.uf, r.lat);
      end
      release_out();
    end
  endtask

  task automatic test_back_pressure();
    res_t r;
    int lat;
    r = model(24'h000001, 24'hFFFFFF, 8'd100);
    issue(24'h000001, 24'hFFFFFF, 8'd100);
    wait_result(lat);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a_man = WIDTH'($urandom); b_man = WIDTH'($urandom); exp_in = EXP_W'($urandom);
      @(posedge clk);
      #1;
      n_cmp++;
      if ({out_valid, in_ready, diff_man, exp_out, sign, zero, underflow} !==
          {2'b10, r.man, r.e, r.sign, r.zero, r.uf}) begin
        n_err++;
        $display("FAIL backpressure_hold%0d: vld=%b rdy=%b man=%h exp=%0d s=%b z=%b uf=%b want vld=1 rdy=0 man=%h exp=%0d s=%b z=%b uf=%b",
                 c, out_valid, in_ready, diff_man, exp_out, sign, zero, underflow, r.man, r.e, r.sign, r.zero, r.uf);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_out();
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL backpressure_release: vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL backpressure_idle: vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_midflight();
    test_random();
    test_back_pressure();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
